// File: rtl/ee_pkg.sv
// Shared types and constants for the EEPROM write-request sequencer.
package ee_pkg;

    localparam int unsigned ACK_TMO_W = 4;
    localparam int unsigned WD_W      = 13;

    localparam logic [ACK_TMO_W-1:0] ACK_TMO_DEF  = 4'd8;
    localparam logic [WD_W-1:0]      WD_LIMIT_DEF = 13'd4000;
    localparam logic [WD_W-1:0]      WD_MAX       = {WD_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_PROG = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // Watchdog increment that sticks at all-ones instead of wrapping
    function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
        return (v == WD_MAX) ? v : v + WD_W'(1);
    endfunction

endpackage

// File: rtl/ee_wr_req_module_if.sv
// Command, program-timer handshake and status signals of the write-request sequencer.
interface ee_wr_req_module_if;
    import ee_pkg::*;

    logic                 wr_cmd_vld;
    logic                 wr_page;
    logic                 wel;
    logic                 ee_wbusy;
    logic                 ee_wdone;
    logic [ACK_TMO_W-1:0] ack_tmo;
    logic [WD_W-1:0]      wd_limit;

    logic                 ee_wbusy_s;
    logic                 wr_ack;
    logic                 wr_err;
    logic                 wel_clr;
    logic                 cmd_drop;
    logic                 rdy_n;
    logic                 page_mode;

    modport master (
        output wr_cmd_vld, wr_page, wel, ee_wbusy, ee_wdone, ack_tmo, wd_limit,
        input  ee_wbusy_s, wr_ack, wr_err, wel_clr, cmd_drop, rdy_n, page_mode
    );

    modport slave (
        input  wr_cmd_vld, wr_page, wel, ee_wbusy, ee_wdone, ack_tmo, wd_limit,
        output ee_wbusy_s, wr_ack, wr_err, wel_clr, cmd_drop, rdy_n, page_mode
    );

endinterface

// File: rtl/ee_wr_req_module.sv
// Write-request sequencer: requests programming from the program timer, waits for
// its handshake and completion under timeout/watchdog, and reports ack or error.
module ee_wr_req_module
    import ee_pkg::*;
(
    input  logic              timer_clk,
    input  logic              sys_rst,
    ee_wr_req_module_if.slave bus
);

    state_e               state_q, state_d;
    logic [ACK_TMO_W-1:0] tmo_q, tmo_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 page_q, page_d;

    logic busy_s_q, busy_s_d;
    logic ack_q, ack_d;
    logic err_q, err_d;
    logic wel_clr_q, wel_clr_d;
    logic drop_q, drop_d;
    logic rdy_n_q, rdy_n_d;

    always_ff @(posedge timer_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            page_q    <= 1'b0;
            busy_s_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            wel_clr_q <= 1'b0;
            drop_q    <= 1'b0;
            rdy_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            page_q    <= page_d;
            busy_s_q  <= busy_s_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            wel_clr_q <= wel_clr_d;
            drop_q    <= drop_d;
            rdy_n_q   <= rdy_n_d;
        end
    end

    // Saturating PROG-state watchdog
    always_ff @(posedge timer_clk) begin
        if (sys_rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        wd_d    = wd_q;
        page_d  = page_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.wr_cmd_vld && bus.wel) begin
                    state_d = ST_REQ;
                    page_d  = bus.wr_page;
                    tmo_d   = '0;
                end
            end
            ST_REQ: begin
                if (bus.ee_wbusy) begin
                    state_d = ST_PROG;
                    tmo_d   = '0;
                    wd_d    = '0;
                end else if (tmo_q == bus.ack_tmo) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + ACK_TMO_W'(1);
                end
            end
            ST_PROG: begin
                // Completion (pulse or busy dropping) beats a watchdog hit in the same cycle
                if (bus.ee_wdone || !bus.ee_wbusy) begin
                    state_d = ST_DONE;
                end else if (wd_q == bus.wd_limit) begin
                    state_d = ST_ERR;
                end else begin
                    wd_d = wd_sat_inc(wd_q);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it
        busy_s_d  = (state_d == ST_REQ) || (state_d == ST_PROG);
        ack_d     = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
        wel_clr_d = ack_d || err_d;
        drop_d    = bus.wr_cmd_vld && (state_q != ST_IDLE);
        rdy_n_d   = (state_d != ST_IDLE) || bus.ee_wbusy;
    end

    assign bus.ee_wbusy_s = busy_s_q;
    assign bus.wr_ack     = ack_q;
    assign bus.wr_err     = err_q;
    assign bus.wel_clr    = wel_clr_q;
    assign bus.cmd_drop   = drop_q;
    assign bus.rdy_n      = rdy_n_q;
    assign bus.page_mode  = page_q;

endmodule

// File: tb/tb_ee_wr_req_module.sv
// Bench for ee_wr_req_module: cycle-accurate transaction model plus directed scenarios.
module tb_ee_wr_req_module;
    import ee_pkg::*;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_PROG = 2;
    localparam int M_DONE = 3;
    localparam int M_ERR  = 4;

    logic timer_clk = 1'b0;
    logic sys_rst;

    ee_wr_req_module_if bus();

    ee_wr_req_module dut (
        .timer_clk (timer_clk),
        .sys_rst   (sys_rst),
        .bus       (bus)
    );

    always #5 timer_clk = ~timer_clk;

    int checks = 0;
    int errors = 0;

    // model state: phase plus the absolute cycle at which the phase was entered
    int   ph = M_IDLE;
    int   enter = 0;
    int   cyc = 0;
    bit   mvalid = 1'b0;
    logic m_busy_s, m_ack, m_err, m_wclr, m_drop, m_rdy_n, m_page;

    // pulse / level tallies for the directed scenarios
    int n_busy_s, n_ack, n_err, n_wclr, n_drop;

    task automatic cmp(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic clr_tally();
        n_busy_s = 0; n_ack = 0; n_err = 0; n_wclr = 0; n_drop = 0;
    endtask

    task automatic pulse_cmd(input logic page);
        bus.wr_cmd_vld = 1'b1;
        bus.wr_page    = page;
        @(negedge timer_clk);
        bus.wr_cmd_vld = 1'b0;
        bus.wr_page    = 1'b0;
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge timer_clk);
    endtask

    // Model update on the active edge, then compare once DUT registers settled
    always @(posedge timer_clk) begin
        int age;
        if (sys_rst) begin
            ph = M_IDLE; m_page = 1'b0;
            m_busy_s = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_wclr = 1'b0;
            m_drop = 1'b0; m_rdy_n = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            m_drop = bus.wr_cmd_vld && (ph != M_IDLE);
            age = cyc - enter;
            if (age > 8191) age = 8191;
            case (ph)
                M_IDLE: if (bus.wr_cmd_vld && bus.wel) begin
                    ph = M_REQ; enter = cyc + 1; m_page = bus.wr_page;
                end
                M_REQ: begin
                    if (bus.ee_wbusy) begin ph = M_PROG; enter = cyc + 1; end
                    else if (age == int'(bus.ack_tmo)) ph = M_ERR;
                end
                M_PROG: begin
                    if (bus.ee_wdone || !bus.ee_wbusy) ph = M_DONE;
                    else if (age == int'(bus.wd_limit)) ph = M_ERR;
                end
                default: ph = M_IDLE;
            endcase
            m_busy_s = (ph == M_REQ) || (ph == M_PROG);
            m_ack    = (ph == M_DONE);
            m_err    = (ph == M_ERR);
            m_wclr   = m_ack || m_err;
            m_rdy_n  = (ph != M_IDLE) || bus.ee_wbusy;
        end
        cyc++;
        #1;
        if (mvalid) begin
            cmp("ee_wbusy_s", bus.ee_wbusy_s, m_busy_s);
            cmp("wr_ack",     bus.wr_ack,     m_ack);
            cmp("wr_err",     bus.wr_err,     m_err);
            cmp("wel_clr",    bus.wel_clr,    m_wclr);
            cmp("cmd_drop",   bus.cmd_drop,   m_drop);
            cmp("rdy_n",      bus.rdy_n,      m_rdy_n);
            cmp("page_mode",  bus.page_mode,  m_page);
            if (bus.ee_wbusy_s === 1'b1) n_busy_s++;
            if (bus.wr_ack     === 1'b1) n_ack++;
            if (bus.wr_err     === 1'b1) n_err++;
            if (bus.wel_clr    === 1'b1) n_wclr++;
            if (bus.cmd_drop   === 1'b1) n_drop++;
        end
    end

    initial begin
        sys_rst        = 1'b1;
        bus.wr_cmd_vld = 1'b0;
        bus.wr_page    = 1'b0;
        bus.wel        = 1'b0;
        bus.ee_wbusy   = 1'b0;
        bus.ee_wdone   = 1'b0;
        bus.ack_tmo    = ACK_TMO_DEF;
        bus.wd_limit   = WD_LIMIT_DEF;
        clr_tally();

        waitn(3);
        chk("reset_busy_s", int'(bus.ee_wbusy_s), 0);
        chk("reset_rdy_n",  int'(bus.rdy_n), 0);
        chk("reset_page",   int'(bus.page_mode), 0);
        sys_rst = 1'b0;
        waitn(2);

        // nominal write: busy after 3 REQ cycles, wdone on 500th PROG cycle
        clr_tally();
        bus.wel = 1'b1;
        pulse_cmd(1'b0);
        waitn(3);
        bus.ee_wbusy = 1'b1;
        waitn(500);
        bus.ee_wdone = 1'b1;
        @(negedge timer_clk);
        bus.ee_wdone = 1'b0;
        bus.ee_wbusy = 1'b0;
        chk("nom_ack_now",  int'(bus.wr_ack), 1);
        chk("nom_wclr_now", int'(bus.wel_clr), 1);
        waitn(3);
        chk("nom_busy_cycles", n_busy_s, 504);
        chk("nom_ack_count",   n_ack, 1);
        chk("nom_err_count",   n_err, 0);

        // handshake timeout with ack_tmo=4
        clr_tally();
        bus.ack_tmo = 4'd4;
        pulse_cmd(1'b0);
        waitn(10);
        chk("tmo_busy_cycles", n_busy_s, 5);
        chk("tmo_err_count",   n_err, 1);
        chk("tmo_ack_count",   n_ack, 0);
        chk("tmo_busy_s_end",  int'(bus.ee_wbusy_s), 0);
        bus.ack_tmo = ACK_TMO_DEF;

        // watchdog expiry at PROG cycle 101
        clr_tally();
        bus.wd_limit = 13'd100;
        bus.ee_wbusy = 1'b1;
        @(negedge timer_clk);
        pulse_cmd(1'b0);
        waitn(110);
        bus.ee_wbusy = 1'b0;
        waitn(3);
        chk("wd_busy_cycles", n_busy_s, 102);
        chk("wd_err_count",   n_err, 1);
        chk("wd_ack_count",   n_ack, 0);

        // wdone coinciding with the watchdog limit wins
        clr_tally();
        bus.ee_wbusy = 1'b1;
        @(negedge timer_clk);
        pulse_cmd(1'b0);
        waitn(101);
        bus.ee_wdone = 1'b1;
        @(negedge timer_clk);
        bus.ee_wdone = 1'b0;
        bus.ee_wbusy = 1'b0;
        waitn(3);
        chk("wdtie_busy_cycles", n_busy_s, 102);
        chk("wdtie_ack_count",   n_ack, 1);
        chk("wdtie_err_count",   n_err, 0);
        bus.wd_limit = WD_LIMIT_DEF;

        // drops: wel=0 ignored, cmd during PROG pulses cmd_drop
        clr_tally();
        bus.wel = 1'b0;
        pulse_cmd(1'b0);
        waitn(3);
        chk("wel0_busy_cycles", n_busy_s, 0);
        chk("wel0_drop_count",  n_drop, 0);
        bus.wel = 1'b1;
        bus.ee_wbusy = 1'b1;
        pulse_cmd(1'b0);
        waitn(5);
        pulse_cmd(1'b1);
        waitn(5);
        bus.ee_wdone = 1'b1;
        @(negedge timer_clk);
        bus.ee_wdone = 1'b0;
        bus.ee_wbusy = 1'b0;
        waitn(3);
        chk("drop_count",     n_drop, 1);
        chk("drop_ack_count", n_ack, 1);
        chk("drop_page",      int'(bus.page_mode), 0);

        // page latch held through DONE; rdy_n held while timer drains
        clr_tally();
        bus.ee_wbusy = 1'b1;
        pulse_cmd(1'b1);
        waitn(5);
        bus.ee_wdone = 1'b1;
        @(negedge timer_clk);
        bus.ee_wdone = 1'b0;
        chk("page_ack_now",  int'(bus.wr_ack), 1);
        chk("page_in_done",  int'(bus.page_mode), 1);
        waitn(3);
        chk("page_idle_rdy_n", int'(bus.rdy_n), 1);
        chk("page_idle_busys", int'(bus.ee_wbusy_s), 0);
        bus.ee_wbusy = 1'b0;
        waitn(2);
        chk("page_idle_rdy_n_low", int'(bus.rdy_n), 0);

        // reset in the middle of PROG
        bus.ee_wbusy = 1'b1;
        pulse_cmd(1'b1);
        waitn(20);
        clr_tally();
        sys_rst = 1'b1;
        @(negedge timer_clk);
        sys_rst = 1'b0;
        bus.ee_wbusy = 1'b0;
        chk("rst_busy_s", int'(bus.ee_wbusy_s), 0);
        chk("rst_page",   int'(bus.page_mode), 0);
        chk("rst_rdy_n",  int'(bus.rdy_n), 0);
        waitn(5);
        chk("rst_ack_count",  n_ack, 0);
        chk("rst_err_count",  n_err, 0);
        chk("rst_wclr_count", n_wclr, 0);

        // randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            bus.wr_cmd_vld = ($urandom % 6) == 0;
            bus.wr_page    = 1'($urandom % 2);
            bus.wel        = ($urandom % 4) != 0;
            if (($urandom % 16) == 0) bus.ee_wbusy = ~bus.ee_wbusy;
            bus.ee_wdone   = ($urandom % 32) == 0;
            if (($urandom % 64) == 0) bus.ack_tmo  = 4'($urandom_range(0, 15));
            if (($urandom % 64) == 0) bus.wd_limit = 13'($urandom_range(0, 40));
            sys_rst        = ($urandom % 300) == 0;
            @(negedge timer_clk);
        end
        sys_rst = 1'b0;
        bus.wr_cmd_vld = 1'b0;
        bus.ee_wdone   = 1'b0;
        waitn(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ee_wr_req_module.md
EE_WR_REQ_MODULE -- requirements
Module: ee_wr_req_module

Interface
REQ-001 SHALL have ports: timer_clk in 1, sole clock; sys_rst in 1, synchronous active-high reset.
REQ-002 SHALL have ports: wr_cmd_vld in 1, one-cycle pulse from the SPI decoder for an accepted byte/page write; wr_page in 1, page (1) or byte (0) write, sampled with wr_cmd_vld.
REQ-003 SHALL have ports: wel in 1, write-enable latch; ee_wbusy in 1, programming-active level from the program timer; ee_wdone in 1, programming-complete pulse from the program timer.
REQ-004 SHALL have ports: ack_tmo in 4, cycles to wait for ee_wbusy; wd_limit in 13, watchdog limit for the PROG state.
REQ-005 SHALL have ports: ee_wbusy_s out 1, program request level to the program timer; wr_ack out 1, success pulse; wr_err out 1, failure pulse; wel_clr out 1, pulse; cmd_drop out 1, pulse; rdy_n out 1, status-register busy bit; page_mode out 1, latched wr_page.

Function
REQ-006 SHALL implement FSM states IDLE, REQ, PROG, DONE, ERR, one-hot or binary.
REQ-007 IDLE: when wr_cmd_vld=1 and wel=1, the FSM SHALL go to REQ, latch page_mode<=wr_page, and clear the timeout counter.
REQ-008 wr_cmd_vld with wel=0 in IDLE SHALL be ignored, with no output change.
REQ-009 REQ: ee_wbusy_s=1; the 4-bit counter SHALL increment each cycle.
REQ-010 From REQ, ee_wbusy=1 SHALL cause a move to PROG and clear the counter.
REQ-011 From REQ, a counter equal to ack_tmo with ee_wbusy=0 SHALL cause a move to ERR.
REQ-012 ack_tmo=0 SHALL time out on the first REQ cycle unless ee_wbusy is already 1 in that cycle.
REQ-013 PROG: ee_wbusy_s=1; the 13-bit watchdog SHALL increment each cycle and saturate at 8191.
REQ-014 From PROG, ee_wdone=1 SHALL cause a move to DONE; ee_wbusy falling to 0 without ee_wdone SHALL also cause a move to DONE.
REQ-015 From PROG, watchdog == wd_limit SHALL cause a move to ERR; if ee_wdone occurs in the same cycle, ee_wdone SHALL win and the FSM goes to DONE.
REQ-016 DONE: the FSM SHALL stay one cycle; wr_ack=1 and wel_clr=1 for that cycle; ee_wbusy_s=0; next state IDLE.
REQ-017 ERR: the FSM SHALL stay one cycle; wr_err=1 and wel_clr=1; ee_wbusy_s=0; next state IDLE.
REQ-018 ee_wbusy_s SHALL be registered and equal 1 exactly while the state is REQ or PROG.
REQ-019 rdy_n SHALL equal 1 in every state other than IDLE, and also in IDLE while ee_wbusy=1 (program timer still draining).
REQ-020 wr_cmd_vld in any non-IDLE state SHALL be dropped and pulse cmd_drop for one cycle; the FSM SHALL be unaffected.
REQ-021 wr_cmd_vld arriving in the DONE/ERR cycle SHALL be dropped; it is accepted only in IDLE.
REQ-022 All outputs SHALL be registered, with one cycle latency from the causing input.
REQ-023 Counters SHALL compare unsigned; there SHALL be no wrap in the watchdog (saturating).

Reset
REQ-024 sys_rst=1 SHALL force state IDLE and clear both counters.
REQ-025 sys_rst=1 SHALL drive all outputs to 0, including page_mode, in the next timer_clk edge.
REQ-026 Reset asserted mid-REQ/PROG SHALL drop ee_wbusy_s with no wr_ack, wr_err or wel_clr pulse.

Structure
REQ-027 State encodings, ACK_TMO_DEF=4'd8 and WD_LIMIT_DEF=13'd4000 SHALL reside in the shared ee_pkg package.
REQ-028 The block SHALL be a single module with no sub-module; the saturating watchdog MAY be a local always block.

Verification
REQ-029 Scenario, nominal write: wel=1, wr_cmd_vld pulse, ee_wbusy rises 3 cycles later, ee_wdone 500 cycles later -> ee_wbusy_s high about 504 cycles, then wr_ack=1 and wel_clr=1 for 1 cycle.
REQ-030 Scenario, handshake timeout: ack_tmo=4, ee_wbusy held 0 -> ERR after 5 REQ cycles; wr_err pulse; ee_wbusy_s=0.
REQ-031 Scenario, watchdog: wd_limit=100, ee_wbusy=1 and no ee_wdone -> wr_err at cycle 101 of PROG; ee_wdone in the same cycle as the limit -> wr_ack instead.
REQ-032 Scenario, drops: wel=0 cmd -> no effect; cmd during PROG -> cmd_drop pulse, and completion still produces exactly one wr_ack.
REQ-033 Scenario, reset mid-PROG: sys_rst for 1 cycle -> all outputs 0 the next cycle, state IDLE, no ack or err pulse.
REQ-034 Scenario, page latch: wr_page=1 with cmd -> page_mode=1 through DONE; rdy_n stays 1 in IDLE while ee_wbusy remains 1.
